// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned RES_W      = 2 * DW_DEFAULT;

    localparam logic [RES_W-1:0] ERR_RESULT = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches upward from the last granted index, with wrap-around.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx
);

    logic [IDW-1:0] ptr;
    logic           found;
    int unsigned    cand;

    // First requester after ptr wins; ptr itself is checked last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            if (!found && req[cand[IDW-1:0]]) begin
                found                  = 1'b1;
                grant[cand[IDW-1:0]]   = 1'b1;
                grant_idx              = cand[IDW-1:0];
            end
        end
    end

    // Reset to the top index so requester 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDW'(N_REQ - 1);
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one sequential multiplier among N_REQ requesters.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to add the RUN timeout and the rsp_err port.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = DW_DEFAULT,
    parameter int unsigned IDW     = $clog2(N_REQ),
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_multiplicand,
    input  logic [N_REQ*DW-1:0] req_multiplier,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*DW-1:0]     rsp_result,
`ifdef MULT_ARB_TIMEOUT_EN
    output logic                rsp_err,
`endif
    output logic                busy,
    output logic [DW-1:0]       data_multiplicand,
    output logic [DW-1:0]       data_multiplier,
    input  logic [2*DW-1:0]     data_result,
    output logic                ctrl_enable,
    input  logic                ctrl_done
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mult_arbiter: unsupported N_REQ or TIMEOUT");
    end

    state_t             state, state_nx;
    logic [N_REQ-1:0]   grant;
    logic [IDW-1:0]     grant_idx;
    logic               accept;
    logic               tmo;

    logic               ctrl_enable_nx;
    logic               busy_nx;
    logic [N_REQ-1:0]   rsp_valid_nx;
    logic [IDW-1:0]     rsp_id_nx;
    logic [2*DW-1:0]    rsp_result_nx;
    logic [DW-1:0]      mcand_nx;
    logic [DW-1:0]      mplier_nx;
    logic               err_nx;

    assign accept = (state == IDLE) && (|grant);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // Cycles spent in RUN; saturates at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == RUN && cnt != CNT_W'(TIMEOUT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tmo = (state == RUN) && (cnt == CNT_W'(TIMEOUT));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|grant) state_nx = RUN;
            RUN:     if (ctrl_done || tmo) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Combinational ready strobe plus next values of the registered outputs.
    always_comb begin
        req_ready      = '0;
        ctrl_enable_nx = ctrl_enable;
        rsp_valid_nx   = '0;
        rsp_id_nx      = rsp_id;
        rsp_result_nx  = rsp_result;
        mcand_nx       = data_multiplicand;
        mplier_nx      = data_multiplier;
        err_nx         = 1'b0;
        busy_nx        = (state_nx != IDLE);
        case (state)
            IDLE: begin
                req_ready = grant;
                if (accept) begin
                    ctrl_enable_nx = 1'b1;
                    rsp_id_nx      = grant_idx;
                    mcand_nx       = req_multiplicand[32'(grant_idx)*DW +: DW];
                    mplier_nx      = req_multiplier[32'(grant_idx)*DW +: DW];
                end
            end
            RUN: begin
                if (ctrl_done) begin
                    ctrl_enable_nx       = 1'b0;
                    rsp_result_nx        = data_result;
                    rsp_valid_nx[rsp_id] = 1'b1;
                end else if (tmo) begin
                    ctrl_enable_nx       = 1'b0;
                    rsp_result_nx        = '1;
                    rsp_valid_nx[rsp_id] = 1'b1;
                    err_nx               = 1'b1;
                end
            end
            RESP: begin
                ctrl_enable_nx = 1'b0;
            end
            default: begin
                ctrl_enable_nx = 1'b0;
            end
        endcase
    end

    // Async reset drops ctrl_enable immediately, abandoning any in-flight multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_enable       <= 1'b0;
            busy              <= 1'b0;
            rsp_valid         <= '0;
            rsp_id            <= '0;
            rsp_result        <= '0;
            data_multiplicand <= '0;
            data_multiplier   <= '0;
        end else begin
            ctrl_enable       <= ctrl_enable_nx;
            busy              <= busy_nx;
            rsp_valid         <= rsp_valid_nx;
            rsp_id            <= rsp_id_nx;
            rsp_result        <= rsp_result_nx;
            data_multiplicand <= mcand_nx;
            data_multiplier   <= mplier_nx;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= err_nx;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_nx;
`endif

endmodule
